// File: rtl/dvi_tmds_pkg.sv
// Shared TMDS constants and helpers for the DVI encoder slice.
// Optional build macro: TMDS_CTL_INPUTS_EN (see dvi_tmds_encoder).
package dvi_tmds_pkg;

  localparam int unsigned SYMBOL_W = 10;

  localparam logic [SYMBOL_W-1:0] CTL_SYM_00 = 10'b1101010100;
  localparam logic [SYMBOL_W-1:0] CTL_SYM_01 = 10'b0010101011;
  localparam logic [SYMBOL_W-1:0] CTL_SYM_10 = 10'b0101010100;
  localparam logic [SYMBOL_W-1:0] CTL_SYM_11 = 10'b1010101011;
  localparam logic [SYMBOL_W-1:0] CLOCK_WORD = 10'b0000011111;

  // Which DC-balance rule the final stage applies to a data symbol.
  typedef enum logic [1:0] {
    BAL_NEUTRAL,
    BAL_INVERT,
    BAL_KEEP
  } balance_t;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  function automatic logic [SYMBOL_W-1:0] ctl_symbol(input logic c1, input logic c0);
    logic [SYMBOL_W-1:0] s;
    unique case ({c1, c0})
      2'b00:   s = CTL_SYM_00;
      2'b01:   s = CTL_SYM_01;
      2'b10:   s = CTL_SYM_10;
      default: s = CTL_SYM_11;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/dvi_tmds_encoder_channel.sv
// Single TMDS channel: 3-stage pipeline (count, transition-minimise, DC balance)
// with its own running disparity counter.
module tmds_channel_encoder
  import dvi_tmds_pkg::*;
(
  input  logic                clk_pixel,
  input  logic                rst_n,
  input  logic [7:0]          data,
  input  logic                c0,
  input  logic                c1,
  input  logic                de,
  output logic [SYMBOL_W-1:0] symbol
);

  // Stage 1: capture inputs and the ones count of the data byte.
  logic [7:0] s1_data;
  logic [3:0] s1_n1;
  logic       s1_de;
  logic [1:0] s1_c;

  always_ff @(posedge clk_pixel) begin
    if (!rst_n) begin
      s1_data <= '0;
      s1_n1   <= '0;
      s1_de   <= 1'b0;
      s1_c    <= '0;
    end else begin
      s1_data <= data;
      s1_n1   <= popcount8(data);
      s1_de   <= de;
      s1_c    <= {c1, c0};
    end
  end

  // Stage 2: XOR/XNOR chaining to minimise transitions.
  logic [8:0] qm;

  always_comb begin
    logic       use_xnor;
    logic [7:0] chain;
    use_xnor = (s1_n1 > 4'd4) || ((s1_n1 == 4'd4) && !s1_data[0]);
    chain    = '0;
    chain[0] = s1_data[0];
    for (int unsigned i = 1; i < 8; i++) begin
      chain[i] = use_xnor ? ~(chain[i-1] ^ s1_data[i]) : (chain[i-1] ^ s1_data[i]);
    end
    qm = {~use_xnor, chain};
  end

  logic [8:0] s2_qm;
  logic [3:0] s2_n1;
  logic       s2_de;
  logic [1:0] s2_c;

  always_ff @(posedge clk_pixel) begin
    if (!rst_n) begin
      s2_qm <= '0;
      s2_n1 <= '0;
      s2_de <= 1'b0;
      s2_c  <= '0;
    end else begin
      s2_qm <= qm;
      s2_n1 <= popcount8(qm[7:0]);
      s2_de <= s1_de;
      s2_c  <= s1_c;
    end
  end

  // Stage 3: DC balance against the running disparity.
  logic signed [4:0]   cnt;
  logic signed [4:0]   cnt_next;
  logic signed [4:0]   n1_s;
  logic signed [4:0]   n0_s;
  logic signed [4:0]   diff;
  logic signed [4:0]   two_q8;
  logic signed [4:0]   two_nq8;
  logic [SYMBOL_W-1:0] sym_next;
  balance_t            bal;

  always_comb begin
    n1_s     = signed'({1'b0, s2_n1});
    n0_s     = 5'sd8 - n1_s;
    diff     = n1_s - n0_s;
    two_q8   = s2_qm[8] ? 5'sd2 : 5'sd0;
    two_nq8  = s2_qm[8] ? 5'sd0 : 5'sd2;
    bal      = BAL_KEEP;
    sym_next = ctl_symbol(s2_c[1], s2_c[0]);
    cnt_next = '0;
    if (s2_de) begin
      if ((cnt == 5'sd0) || (diff == 5'sd0)) begin
        bal = BAL_NEUTRAL;
      end else if (((cnt > 5'sd0) && (diff > 5'sd0)) || ((cnt < 5'sd0) && (diff < 5'sd0))) begin
        bal = BAL_INVERT;
      end else begin
        bal = BAL_KEEP;
      end
      unique case (bal)
        BAL_NEUTRAL: begin
          sym_next = {~s2_qm[8], s2_qm[8], s2_qm[8] ? s2_qm[7:0] : ~s2_qm[7:0]};
          cnt_next = s2_qm[8] ? (cnt + diff) : (cnt - diff);
        end
        BAL_INVERT: begin
          sym_next = {1'b1, s2_qm[8], ~s2_qm[7:0]};
          cnt_next = cnt + two_q8 - diff;
        end
        default: begin
          sym_next = {1'b0, s2_qm[8], s2_qm[7:0]};
          cnt_next = cnt - two_nq8 + diff;
        end
      endcase
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (!rst_n) begin
      symbol <= CTL_SYM_00;
      cnt    <= '0;
    end else begin
      symbol <= sym_next;
      cnt    <= cnt_next;
    end
  end

endmodule

// File: rtl/dvi_tmds_encoder.sv
// DVI TMDS encoder top: blank alignment delay plus three channel encoders.
// Define TMDS_CTL_INPUTS_EN to add in_ctl[3:0] driving green/red control codes.
module dvi_tmds_encoder
  import dvi_tmds_pkg::*;
#(
  parameter int unsigned C_blank_delay = 1
) (
  input  logic                clk_pixel,
  input  logic                rst_n,
  input  logic [7:0]          in_red,
  input  logic [7:0]          in_green,
  input  logic [7:0]          in_blue,
  input  logic                in_hsync,
  input  logic                in_vsync,
  input  logic                in_blank,
`ifdef TMDS_CTL_INPUTS_EN
  input  logic [3:0]          in_ctl,
`endif
  output logic [SYMBOL_W-1:0] tmds_red,
  output logic [SYMBOL_W-1:0] tmds_green,
  output logic [SYMBOL_W-1:0] tmds_blue,
  output logic [SYMBOL_W-1:0] tmds_clock
);

  logic de;

  // Upstream blank leads the pixel data; delay it so de lines up with the data.
  if (C_blank_delay == 0) begin : g_no_delay
    assign de = ~in_blank;
  end else begin : g_delay
    logic [C_blank_delay-1:0] blank_sr;

    always_ff @(posedge clk_pixel) begin
      if (!rst_n) begin
        blank_sr <= '1;
      end else begin
        blank_sr[0] <= in_blank;
        for (int unsigned i = 1; i < C_blank_delay; i++) begin
          blank_sr[i] <= blank_sr[i-1];
        end
      end
    end

    assign de = ~blank_sr[C_blank_delay-1];
  end

  logic [1:0] ctl_green;
  logic [1:0] ctl_red;

`ifdef TMDS_CTL_INPUTS_EN
  assign ctl_green = in_ctl[1:0];
  assign ctl_red   = in_ctl[3:2];
`else
  assign ctl_green = '0;
  assign ctl_red   = '0;
`endif

  tmds_channel_encoder u_blue (
    .clk_pixel (clk_pixel),
    .rst_n     (rst_n),
    .data      (in_blue),
    .c0        (in_hsync),
    .c1        (in_vsync),
    .de        (de),
    .symbol    (tmds_blue)
  );

  tmds_channel_encoder u_green (
    .clk_pixel (clk_pixel),
    .rst_n     (rst_n),
    .data      (in_green),
    .c0        (ctl_green[0]),
    .c1        (ctl_green[1]),
    .de        (de),
    .symbol    (tmds_green)
  );

  tmds_channel_encoder u_red (
    .clk_pixel (clk_pixel),
    .rst_n     (rst_n),
    .data      (in_red),
    .c0        (ctl_red[0]),
    .c1        (ctl_red[1]),
    .de        (de),
    .symbol    (tmds_red)
  );

  assign tmds_clock = CLOCK_WORD;

endmodule

// File: tb/tb_dvi_tmds_encoder.sv
// Self-checking bench for dvi_tmds_encoder: vector table, hand sequences and
// randomized traffic against a behavioural TMDS encode/decode model.
module tb_dvi_tmds_encoder;

  localparam int unsigned D = 1;
`ifdef TMDS_CTL_INPUTS_EN
  localparam bit CTL_EN = 1'b1;
`else
  localparam bit CTL_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_red, in_green, in_blue;
  logic       in_hsync, in_vsync, in_blank;
  logic [3:0] ctl;
  logic [9:0] tmds_red, tmds_green, tmds_blue, tmds_clock;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  dvi_tmds_encoder #(.C_blank_delay(D)) dut (
    .clk_pixel  (clk),
    .rst_n      (rst_n),
    .in_red     (in_red),
    .in_green   (in_green),
    .in_blue    (in_blue),
    .in_hsync   (in_hsync),
    .in_vsync   (in_vsync),
    .in_blank   (in_blank),
`ifdef TMDS_CTL_INPUTS_EN
    .in_ctl     (ctl),
`endif
    .tmds_red   (tmds_red),
    .tmds_green (tmds_green),
    .tmds_blue  (tmds_blue),
    .tmds_clock (tmds_clock)
  );

  // Reference model: channel index 0=blue, 1=green, 2=red.
  typedef struct packed {
    logic            de;
    logic [2:0][1:0] c;
    logic [2:0][7:0] d;
  } rec_t;

  rec_t       pipe0, pipe1;
  int         mcnt [3];
  int         disp [3];
  logic [3:0] bl_hist;
  logic [9:0] exp_sym [3];
  string      ch_name [3] = '{"blue", "green", "red"};

  function automatic logic [9:0] ref_enc(input logic [7:0] d, input logic de,
                                         input logic [1:0] c, inout int cnt);
    int         n1, ones, diff;
    bit         xn, q8;
    logic [7:0] q;
    if (!de) begin
      cnt = 0;
      case (c)
        2'd0:    return 10'h354;
        2'd1:    return 10'h0AB;
        2'd2:    return 10'h154;
        default: return 10'h2AB;
      endcase
    end
    n1   = $countones(d);
    xn   = (n1 > 4) || (n1 == 4 && d[0] == 1'b0);
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q8   = !xn;
    ones = $countones(q);
    diff = 2 * ones - 8;
    if (cnt == 0 || diff == 0) begin
      cnt = q8 ? cnt + diff : cnt - diff;
      return {~q8, q8, q8 ? q : ~q};
    end else if ((cnt > 0 && diff > 0) || (cnt < 0 && diff < 0)) begin
      cnt = cnt + (q8 ? 2 : 0) - diff;
      return {1'b1, q8, ~q};
    end else begin
      cnt = cnt + diff - (q8 ? 0 : 2);
      return {1'b0, q8, q};
    end
  endfunction

  function automatic logic [7:0] ref_dec(input logic [9:0] s);
    logic [7:0] q, d;
    q    = s[9] ? ~s[7:0] : s[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = s[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    return d;
  endfunction

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock: advance the model on the edge, then compare shortly after it.
  task automatic step();
    logic [9:0] dut_sym [3];
    rec_t       out_rec;
    bit         out_valid;
    logic       de_al;
    int         idx;
    @(posedge clk);
    out_valid = 1'b0;
    out_rec   = '0;
    if (!rst_n) begin
      for (int ch = 0; ch < 3; ch++) begin
        exp_sym[ch] = 10'h354;
        mcnt[ch]    = 0;
        disp[ch]    = 0;
      end
      pipe0   = '0;
      pipe1   = '0;
      bl_hist = '1;
    end else begin
      out_rec   = pipe1;
      out_valid = 1'b1;
      for (int ch = 0; ch < 3; ch++)
        exp_sym[ch] = ref_enc(pipe1.d[ch], pipe1.de, pipe1.c[ch], mcnt[ch]);
      pipe1 = pipe0;
      idx   = (D == 0) ? 0 : int'(D) - 1;
      de_al = (D == 0) ? ~in_blank : ~bl_hist[idx];
      bl_hist    = {bl_hist[2:0], in_blank};
      pipe0.de   = de_al;
      pipe0.c[0] = {in_vsync, in_hsync};
      pipe0.c[1] = CTL_EN ? ctl[1:0] : 2'b00;
      pipe0.c[2] = CTL_EN ? ctl[3:2] : 2'b00;
      pipe0.d[0] = in_blue;
      pipe0.d[1] = in_green;
      pipe0.d[2] = in_red;
    end
    #1;
    dut_sym = '{tmds_blue, tmds_green, tmds_red};
    for (int ch = 0; ch < 3; ch++) check({"sym_", ch_name[ch]}, dut_sym[ch], exp_sym[ch]);
    check("clock_word", tmds_clock, 10'h01F);
    if (out_valid) begin
      for (int ch = 0; ch < 3; ch++) begin
        if (out_rec.de) begin
          check({"decode_", ch_name[ch]}, {2'b00, ref_dec(dut_sym[ch])}, {2'b00, out_rec.d[ch]});
          disp[ch] += 2 * $countones(dut_sym[ch]) - 10;
          n_checks++;
          if (disp[ch] > 10 || disp[ch] < -10) begin
            n_errors++;
            $display("FAIL disparity_%s: got %0d required within +/-10", ch_name[ch], disp[ch]);
          end
        end else begin
          disp[ch] = 0;
        end
      end
    end
  endtask

  task automatic drive(input logic blank, input logic vs, input logic hs,
                       input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
    in_blank = blank;
    in_vsync = vs;
    in_hsync = hs;
    in_red   = r;
    in_green = g;
    in_blue  = b;
  endtask

  typedef struct {
    logic       blank, vs, hs;
    logic [7:0] pix;
    logic [9:0] eb, egr;
  } vec_t;

  localparam int H_ACT = 128, H_TOT = 160, V_ACT = 20, V_TOT = 24;

  function automatic bit active_at(input int p);
    int pp, line, x;
    pp   = p % (H_TOT * V_TOT);
    line = pp / H_TOT;
    x    = pp % H_TOT;
    return (line < V_ACT) && (x < H_ACT);
  endfunction

  vec_t tbl [13];

  initial begin
    rst_n = 1'b0;
    ctl   = 4'b0000;
    drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);

    // Reset, then release while blanked.
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      check("reset_blue", tmds_blue, 10'h354);
      check("reset_red", tmds_red, 10'h354);
    end

    // Sync codes then a 3-pixel black burst (outputs lag inputs by two edges).
    tbl[0]  = '{1'b1, 1'b0, 1'b0, 8'h00, 10'h354, 10'h354};
    tbl[1]  = '{1'b1, 1'b0, 1'b1, 8'h00, 10'h354, 10'h354};
    tbl[2]  = '{1'b1, 1'b1, 1'b0, 8'h00, 10'h354, 10'h354};
    tbl[3]  = '{1'b1, 1'b1, 1'b1, 8'h00, 10'h0AB, 10'h354};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 8'h00, 10'h154, 10'h354};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, 10'h2AB, 10'h354};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 8'h00, 10'h354, 10'h354};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 10'h354, 10'h354};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 8'h00, 10'h100, 10'h100};
    tbl[9]  = '{1'b1, 1'b0, 1'b0, 8'h00, 10'h3FF, 10'h3FF};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 8'h00, 10'h100, 10'h100};
    tbl[11] = '{1'b1, 1'b0, 1'b0, 8'h00, 10'h354, 10'h354};
    tbl[12] = '{1'b1, 1'b0, 1'b0, 8'h00, 10'h354, 10'h354};
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].blank, tbl[i].vs, tbl[i].hs, tbl[i].pix, tbl[i].pix, tbl[i].pix);
      step();
      check("tbl_blue", tmds_blue, tbl[i].eb);
      check("tbl_green", tmds_green, tbl[i].egr);
      check("tbl_red", tmds_red, tbl[i].egr);
    end

    // Control inputs on green/red during blank.
    ctl = 4'b1001;
    for (int i = 0; i < 4; i++) begin
      step();
      if (i >= 2) begin
        check("ctl_green", tmds_green, CTL_EN ? 10'h0AB : 10'h354);
        check("ctl_red", tmds_red, CTL_EN ? 10'h154 : 10'h354);
      end
    end
    ctl = 4'b0000;

    // Random-pixel frame; blank leads pixel data by D cycles.
    for (int p = 0; p < H_TOT * V_TOT; p++) begin
      int line, x;
      bit act;
      line = p / H_TOT;
      x    = p % H_TOT;
      act  = active_at(p);
      drive(!active_at(p + int'(D)),
            (line >= V_ACT + 1) && (line < V_ACT + 3),
            (x >= H_ACT + 4) && (x < H_ACT + 12),
            act ? 8'($urandom) : 8'h00, act ? 8'($urandom) : 8'h00,
            act ? 8'($urandom) : 8'h00);
      ctl = 4'($urandom);
      step();
    end

    // Random blank toggling, including single-cycle active and blank runs.
    for (int i = 0; i < 600; i++) begin
      drive(1'($urandom), 1'($urandom), 1'($urandom),
            8'($urandom), 8'($urandom), 8'($urandom));
      step();
    end

    // Reset mid-line at x=100, then release, blank and a black burst.
    for (int x = 0; x <= 100; x++) begin
      drive(1'b0, 1'b0, 1'b0, 8'($urandom), 8'($urandom), 8'($urandom));
      rst_n = (x != 100);
      step();
    end
    check("midrst_blue", tmds_blue, 10'h354);
    check("midrst_green", tmds_green, 10'h354);
    check("midrst_red", tmds_red, 10'h354);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      step();
      check("postrst_blue", tmds_blue, 10'h354);
    end
    for (int i = 0; i < 5; i++) begin
      drive((i >= 2), 1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
      step();
      if (i == 3) check("postrst_first", tmds_blue, 10'h100);
      if (i == 4) check("postrst_second", tmds_blue, 10'h3FF);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/dvi_tmds_encoder.md
Name: dvi_tmds_encoder

Overview:
- Converts the 8-bit RGB, sync and blank outputs of the VGA timing generator into three 10-bit DVI/TMDS channel words.
- Pipelined: one word per channel per clk_pixel.
- Sits directly downstream of the timing generator, upstream of the DDR serializers.
- Provides the TMDS clock-channel word as well.

Parameters:
C_blank_delay, 1, extra clk_pixel delay applied to blank only; upstream blank leads pixel/sync data by one cycle (0..3 allowed)

Ports:
clk_pixel  input  1  pixel clock; all logic on rising edge
rst_n  input  1  synchronous reset, active low
in_red  input  8  pixel red; zero during blank
in_green  input  8  pixel green
in_blue  input  8  pixel blue
in_hsync  input  1  horizontal sync, aligned with pixel data
in_vsync  input  1  vertical sync, aligned with pixel data
in_blank  input  1  H+V blank, leads pixel data by C_blank_delay cycles
tmds_red  output  10  channel 2 symbol, bit 0 transmitted first
tmds_green  output  10  channel 1 symbol
tmds_blue  output  10  channel 0 symbol
tmds_clock  output  10  constant 10'b0000011111

Behaviour:
- One clock (clk_pixel); reset is synchronous and active-low (rst_n). The port names and polarity are fixed.
- Reset values:
  - All three channel outputs = 10'b1101010100 (control 00).
  - Internal running disparity counters = 0.
  - Blank delay line = all 1s (blanked).
  - tmds_clock is constant and unaffected by reset.
- Alignment:
  - de = ~in_blank delayed C_blank_delay cycles through a shift register.
  - in_blank feeds the shift register; pixel and sync data are not delayed there.
- Pipeline, fixed latency 3 clk_pixel from aligned inputs to outputs:
  - S1: register data, de, c0 and c1. Compute N1(d) as a 4-bit count.
  - S2: build q_m[8:0] by XNOR chaining if N1>4 or (N1==4 and d[0]==0), otherwise XOR chaining. q_m[8]=1 for XOR, 0 for XNOR. Register q_m, N1(q_m[7:0]), de, c.
  - S3: DC balance, per the DVI 1.0 algorithm:
    - Running disparity cnt is 5-bit signed (two's complement). N0-N1 is computed as sign-extended 5-bit.
    - If cnt==0 or N1==N0: out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}. cnt += q_m[8] ? (N1-N0) : (N0-N1).
    - Else if (cnt>0 and N1>N0) or (cnt<0 and N0>N1): out = {1, q_m[8], ~q_m[7:0]}. cnt += 2*q_m[8] + (N0-N1).
    - Else: out = {0, q_m[8], q_m[7:0]}. cnt -= 2*(~q_m[8]) - (N1-N0).
- Control period (de==0 at S3):
  - Emit the control symbol for {c1,c0}:
    - 00 → 10'b1101010100
    - 01 → 10'b0010101011
    - 10 → 10'b0101010100
    - 11 → 10'b1010101011
  - cnt is cleared to 0.
- Channel mapping:
  - Blue: c0=hsync, c1=vsync.
  - Green and red: c=00, unless TMDS_CTL_INPUTS_EN is defined.
- Per-channel independence: each channel keeps its own cnt.
- de edge cases:
  - A de toggle on consecutive cycles is legal, including single-pixel active or blank periods.
  - The first data symbol after blank always starts from cnt=0.
- rst_n low mid-line: outputs show reset values on the next edge. The pipeline flushes; no stale data symbol appears after release.
- Sync polarity is passed through unchanged; no inversion.

Optional Feature:
TMDS_CTL_INPUTS_EN
- Defined: adds input port in_ctl[3:0], delayed with pixel data.
  - Green channel: c0=in_ctl[0], c1=in_ctl[1].
  - Red channel: c0=in_ctl[2], c1=in_ctl[3].
  - These values are used only during de==0.
- Not defined: the port does not exist; red and green control symbols are always 10'b1101010100.

Decomposition:
- Package dvi_tmds_pkg holds:
  - The four control-symbol constants.
  - The clock word constant 10'b0000011111.
  - The symbol width 10.
  - A popcount8 function returning 4 bits.
- One natural sub-module, tmds_channel_encoder: a single-channel 3-stage pipeline with its own cnt and ports clk_pixel, rst_n, data[7:0], c0, c1, de → symbol[9:0]. The top instantiates it three times and adds the blank delay line.

Test Plan:
- Reset:
  - Stimulus: rst_n=0 for 2 cycles, then release with in_blank=1, hsync=vsync=0.
  - Response: all channels = 10'b1101010100 (0x354) throughout; tmds_clock=0x01F.
- Alignment:
  - Stimulus: raise blank→0 with red=green=blue=0x00 for 3 pixels.
  - Response: blue symbols 0x100, 0x3FF, 0x100, with cnt sequence -8, +2, -6. The first data symbol appears exactly 3 cycles after the first pixel and 3+C_blank_delay cycles after the in_blank fall.
- Sync codes:
  - Stimulus: blanked with (vsync,hsync) = 00, 01, 10, 11.
  - Response: blue = 0x354, 0x0AB, 0x154, 0x2AB; red and green stay 0x354.
- DC balance soak:
  - Stimulus: a full 800x525 frame of random pixels.
  - Response: |cnt| never exceeds 10 per channel. The decoded symbol matches the input byte each data cycle (reference decoder in bench). cnt reads 0 after each blank.
- Reset mid-line:
  - Stimulus: assert rst_n=0 during active video at x=100.
  - Response: next edge outputs 0x354; after release and blank, the first data symbol uses cnt=0.
- TMDS_CTL_INPUTS_EN:
  - Stimulus: in_ctl=4'b1001 during blank.
  - Response: green=0x0AB, red=0x154.
  - Without the macro: green=red=0x354.
